sample_mac_pipe: RTL and testbench
==================================

Name: sample_mac_pipe

Overview:
- Parametrised successor to the fixed 13x13 pipelined signed multiplier core used by the HLS-generated datapath.
- Adds configurable operand, output and pipeline widths, a per-sample multiply/accumulate mode, valid/ready handshake with back-pressure, and output rounding and saturation.
- Sits between HLS loop bodies and downstream storage wherever dot products or scaled products are needed.

Parameters:
- DIN0_WIDTH, 13, signed operand A width
- DIN1_WIDTH, 13, signed operand B width
- DOUT_WIDTH, 13, signed result width
- NUM_STAGE, 3, latency in cycles; legal range 3..6
- ACC_GUARD, 4, accumulator guard bits; ACC_W = DIN0_WIDTH + DIN1_WIDTH + ACC_GUARD
- SHIFT, 0, arithmetic right shift applied before output
- ROUND, 0, 1 = round-half-up before shift (only meaningful if SHIFT>0)
- SAT, 0, 1 = saturate to DOUT_WIDTH; 0 = wrap (truncate low bits)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ce  in  1  global clock enable; 0 freezes all state
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts the sample this cycle
- din0  in  DIN0_WIDTH  signed operand A
- din1  in  DIN1_WIDTH  signed operand B
- mode  in  1  0 = multiply, 1 = accumulate; tagged per sample
- in_first  in  1  accumulate mode: clear the accumulator before adding this product
- in_last  in  1  accumulate mode: emit the accumulated result with this sample
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- dout  out  DOUT_WIDTH  signed result
- out_ovf  out  1  saturation occurred on this result (always 0 when SAT=0)

Behaviour:
- Reset (reset=0, asynchronous): all stage valid bits, out_valid, dout, out_ovf and the accumulator go to 0. In-flight samples are discarded. in_ready = 0 while reset is asserted.
- Advance: adv = ce & (~out_valid | out_ready). in_ready = adv. A sample is accepted when in_valid & in_ready. The whole pipeline shifts only when adv=1 (global stall; bubbles are not collapsed).
- Stages:
  - S1 registers din0, din1, mode, first, last and valid.
  - S2 registers the full product, DIN0_WIDTH+DIN1_WIDTH bits, sign-extended to ACC_W.
  - S3..S(NUM_STAGE-1) are pure delay stages.
  - S(NUM_STAGE) is the output/accumulate stage.
- Mode 0 (multiply): the output register loads scale(product) and out_valid=1. Latency is exactly NUM_STAGE cycles from acceptance to out_valid when unstalled. The accumulator is untouched.
- Mode 1 (accumulate): acc_next = (first ? 0 : acc) + product, computed modulo 2^ACC_W. acc <= acc_next on advance.
  - If last=1, the output loads scale(acc_next) and out_valid=1.
  - Otherwise no output is produced and the sample is consumed silently.
  - first & last on the same sample gives a single-product result.
  - last without a prior first accumulates onto the existing acc.
  - Mode-0 samples interleaved within a sequence pass through without disturbing acc.
- scale(v):
  - If ROUND & SHIFT>0, add 2^(SHIFT-1).
  - Arithmetic shift right by SHIFT.
  - SAT=1: clamp to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1] and set out_ovf when clamped.
  - SAT=0: keep the low DOUT_WIDTH bits and set out_ovf=0.
  - Defaults reproduce the legacy truncated 13-bit product.
- Output hold: while out_valid & ~out_ready, dout, out_ovf and out_valid stay stable. out_valid falls after a handshake unless a new result loads in the same cycle.
- ce=0: no state changes; in_ready=0; outputs hold.
- Simultaneous handshake on output and input in one cycle is legal: full throughput of one sample per cycle.

Decomposition:
- Shared package sample_mac_pkg:
  - mode constants MAC_MODE_MUL=0, MAC_MODE_ACC=1
  - function acc_width(a_w, b_w, guard)
  - function sat_fit(value, width) returning value and overflow flag
- Sub-module sample_mac_scale: combinational round/shift/saturate, parametrised by ACC_W, DOUT_WIDTH, SHIFT, ROUND and SAT.

Test Plan:
- Defaults, mode 0, din0=100, din1=-3, one-cycle valid, out_ready=1 -> out_valid exactly 3 cycles later, dout=-300 (13'h1ED4), out_ovf=0.
- din0=4095, din1=4095, mode 0 -> SAT=0 gives dout=1, out_ovf=0; SAT=1 gives dout=4095, out_ovf=1.
- Mode 1, pairs (1,2) first, (3,4), (5,6) last, back-to-back -> single out_valid 3 cycles after the last pair is accepted, dout=44, no earlier out_valid.
- SHIFT=2, ROUND=1, mode 0, samples (3,3) and (-3,3) -> dout=2 then dout=-2.
- Eight back-to-back mode-0 samples, out_ready=0 for 5 cycles from the first out_valid -> in_ready=0 during the stall, dout stable, all eight results delivered in order with no loss or duplication; ce=0 for 4 cycles mid-stream -> identical result sequence.
- reset pulsed low mid-accumulation after (7,7) first -> out_valid=0 immediately (asynchronous); then (2,3) with first & last -> dout=6, with no residue from 49.

Source files
------------

// File: rtl/sample_mac_pkg.sv
// Shared constants and helpers for the sample MAC pipeline.
package sample_mac_pkg;

    localparam logic MAC_MODE_MUL = 1'b0;
    localparam logic MAC_MODE_ACC = 1'b1;

    // Widest value the saturation helper can clamp.
    localparam int SAT_MAX_W = 128;

    function automatic int acc_width(input int a_w, input int b_w, input int guard);
        return a_w + b_w + guard;
    endfunction

    // Clamps a signed value into a signed range of 'width' bits.
    // The result is {overflow, clamped value}.
    function automatic logic [SAT_MAX_W:0] sat_fit(input logic signed [SAT_MAX_W-1:0] value,
                                                    input int width);
        logic signed [SAT_MAX_W-1:0] one;
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        one = {{(SAT_MAX_W-1){1'b0}}, 1'b1};
        hi  = (one <<< (width - 1)) - one;
        lo  = ~hi;
        if (value > hi) begin
            return {1'b1, hi};
        end else if (value < lo) begin
            return {1'b1, lo};
        end
        return {1'b0, value};
    endfunction

endpackage

// File: rtl/sample_mac_pipe_if.sv
// Sample-in / result-out handshake bundle of the MAC pipeline.
interface sample_mac_pipe_if #(
    parameter int DIN0_WIDTH = 13,
    parameter int DIN1_WIDTH = 13,
    parameter int DOUT_WIDTH = 13
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DIN0_WIDTH-1:0] din0;
    logic signed [DIN1_WIDTH-1:0] din1;
    logic                         mode;
    logic                         in_first;
    logic                         in_last;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DOUT_WIDTH-1:0] dout;
    logic                         out_ovf;

    modport master (
        output in_valid, din0, din1, mode, in_first, in_last, out_ready,
        input  in_ready, out_valid, dout, out_ovf
    );

    modport slave (
        input  in_valid, din0, din1, mode, in_first, in_last, out_ready,
        output in_ready, out_valid, dout, out_ovf
    );
endinterface

// File: rtl/sample_mac_scale.sv
// Combinational round / arithmetic shift / saturate-or-wrap of a result.
module sample_mac_scale
    import sample_mac_pkg::*;
#(
    parameter int ACC_W      = 30,
    parameter int DOUT_WIDTH = 13,
    parameter int SHIFT      = 0,
    parameter int ROUND      = 0,
    parameter int SAT        = 0
) (
    input  logic signed [ACC_W-1:0]      value,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         ovf
);
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [ACC_W:0] RND_ADD =
        (ROUND != 0 && SHIFT > 0) ? ((ACC_W+1)'(1) << RND_POS) : '0;

    logic signed [ACC_W:0]       rounded;
    logic signed [ACC_W:0]       shifted;
    logic signed [SAT_MAX_W-1:0] wide;
    logic [SAT_MAX_W:0]          fit;

    // One extra bit keeps the rounding add from wrapping near full scale.
    always_comb begin
        rounded = {value[ACC_W-1], value} + RND_ADD;
        shifted = rounded >>> SHIFT;
        wide    = {{(SAT_MAX_W-ACC_W-1){shifted[ACC_W]}}, shifted};
        fit     = sat_fit(wide, DOUT_WIDTH);
        if (SAT != 0) begin
            dout = fit[DOUT_WIDTH-1:0];
            ovf  = fit[SAT_MAX_W];
        end else begin
            dout = shifted[DOUT_WIDTH-1:0];
            ovf  = 1'b0;
        end
    end
endmodule

// File: rtl/sample_mac_pipe.sv
// Pipelined signed multiplier / accumulator with valid-ready handshake,
// global stall on back-pressure, and configurable output scaling.
module sample_mac_pipe
    import sample_mac_pkg::*;
#(
    parameter int DIN0_WIDTH = 13,
    parameter int DIN1_WIDTH = 13,
    parameter int DOUT_WIDTH = 13,
    parameter int NUM_STAGE  = 3,
    parameter int ACC_GUARD  = 4,
    parameter int SHIFT      = 0,
    parameter int ROUND      = 0,
    parameter int SAT        = 0
) (
    input logic              clk,
    input logic              reset,
    input logic              ce,
    sample_mac_pipe_if.slave bus
);
    localparam int ACC_W   = acc_width(DIN0_WIDTH, DIN1_WIDTH, ACC_GUARD);
    localparam int PROD_W  = DIN0_WIDTH + DIN1_WIDTH;
    localparam int NUM_DLY = NUM_STAGE - 2;

    logic                         adv;
    logic                         s1_valid, s1_mode, s1_first, s1_last;
    logic signed [DIN0_WIDTH-1:0] s1_a;
    logic signed [DIN1_WIDTH-1:0] s1_b;
    logic signed [PROD_W-1:0]     s1_prod;
    logic signed [ACC_W-1:0]      s1_prod_ext;
    logic signed [ACC_W-1:0]      d_prod [NUM_DLY];
    logic [NUM_DLY-1:0]           d_valid, d_mode, d_first, d_last;
    logic signed [ACC_W-1:0]      acc, acc_next, scale_in;
    logic                         load;
    logic signed [DOUT_WIDTH-1:0] scaled, dout_q;
    logic                         scaled_ovf, ovf_q, out_valid_q;

    assign adv           = ce & (~out_valid_q | bus.out_ready);
    assign bus.in_ready  = adv & reset;
    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.out_ovf   = ovf_q;

    // Input stage: capture operands and the per-sample tags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (adv) begin
            s1_valid <= bus.in_valid;
            s1_mode  <= bus.mode;
            s1_first <= bus.in_first;
            s1_last  <= bus.in_last;
            s1_a     <= bus.din0;
            s1_b     <= bus.din1;
        end
    end

    // Full-precision product, sign-extended to the accumulator width.
    always_comb begin
        s1_prod     = PROD_W'(s1_a) * PROD_W'(s1_b);
        s1_prod_ext = ACC_W'(s1_prod);
    end

    // Product register followed by pure delay stages up to the output stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_DLY; i++) begin
                d_prod[i] <= '0;
            end
            d_valid <= '0;
            d_mode  <= '0;
            d_first <= '0;
            d_last  <= '0;
        end else if (adv) begin
            d_prod[0]  <= s1_prod_ext;
            d_valid[0] <= s1_valid;
            d_mode[0]  <= s1_mode;
            d_first[0] <= s1_first;
            d_last[0]  <= s1_last;
            for (int i = 1; i < NUM_DLY; i++) begin
                d_prod[i]  <= d_prod[i-1];
                d_valid[i] <= d_valid[i-1];
                d_mode[i]  <= d_mode[i-1];
                d_first[i] <= d_first[i-1];
                d_last[i]  <= d_last[i-1];
            end
        end
    end

    // Next accumulator value and the value presented to the scaler.
    always_comb begin
        acc_next = (d_first[NUM_DLY-1] ? '0 : acc) + d_prod[NUM_DLY-1];
        scale_in = (d_mode[NUM_DLY-1] == MAC_MODE_ACC) ? acc_next : d_prod[NUM_DLY-1];
        load     = d_valid[NUM_DLY-1] &
                   ((d_mode[NUM_DLY-1] == MAC_MODE_MUL) | d_last[NUM_DLY-1]);
    end

    sample_mac_scale #(
        .ACC_W      (ACC_W),
        .DOUT_WIDTH (DOUT_WIDTH),
        .SHIFT      (SHIFT),
        .ROUND      (ROUND),
        .SAT        (SAT)
    ) u_scale (
        .value (scale_in),
        .dout  (scaled),
        .ovf   (scaled_ovf)
    );

    // Output/accumulate stage; multiply samples never touch the accumulator.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc         <= '0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            ovf_q       <= 1'b0;
        end else if (adv) begin
            if (d_valid[NUM_DLY-1] && d_mode[NUM_DLY-1] == MAC_MODE_ACC) begin
                acc <= acc_next;
            end
            out_valid_q <= load;
            if (load) begin
                dout_q <= scaled;
                ovf_q  <= scaled_ovf;
            end
        end
    end
endmodule

// File: tb/tb_sample_mac_pipe.sv
// Self-checking bench: three configurations (default, saturating, rounded
// shift) driven by one stimulus stream and checked against a sample-level
// arithmetic model.
module tb_sample_mac_pipe;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ce = 1'b1;
    logic in_valid = 1'b0;
    logic signed [12:0] din0 = '0;
    logic signed [12:0] din1 = '0;
    logic mode = 1'b0;
    logic in_first = 1'b0;
    logic in_last = 1'b0;
    logic out_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    // Entry layout: [41:28] rounded config, [27:14] saturating, [13:0] default; each {ovf, dout}.
    logic [41:0] got_q[$];
    logic [41:0] exp_q[$];
    logic [41:0] first_run[$];
    longint model_acc = 0;
    logic signed [12:0] sa[8];
    logic signed [12:0] sb[8];

    always #5 clk = ~clk;

    sample_mac_pipe_if #(.DIN0_WIDTH(13), .DIN1_WIDTH(13), .DOUT_WIDTH(13)) bus_d ();
    sample_mac_pipe_if #(.DIN0_WIDTH(13), .DIN1_WIDTH(13), .DOUT_WIDTH(13)) bus_s ();
    sample_mac_pipe_if #(.DIN0_WIDTH(13), .DIN1_WIDTH(13), .DOUT_WIDTH(13)) bus_r ();

    assign bus_d.in_valid = in_valid;  assign bus_s.in_valid = in_valid;  assign bus_r.in_valid = in_valid;
    assign bus_d.din0 = din0;          assign bus_s.din0 = din0;          assign bus_r.din0 = din0;
    assign bus_d.din1 = din1;          assign bus_s.din1 = din1;          assign bus_r.din1 = din1;
    assign bus_d.mode = mode;          assign bus_s.mode = mode;          assign bus_r.mode = mode;
    assign bus_d.in_first = in_first;  assign bus_s.in_first = in_first;  assign bus_r.in_first = in_first;
    assign bus_d.in_last = in_last;    assign bus_s.in_last = in_last;    assign bus_r.in_last = in_last;
    assign bus_d.out_ready = out_ready; assign bus_s.out_ready = out_ready; assign bus_r.out_ready = out_ready;

    sample_mac_pipe dut_d (.clk(clk), .reset(reset), .ce(ce), .bus(bus_d));
    sample_mac_pipe #(.SAT(1)) dut_s (.clk(clk), .reset(reset), .ce(ce), .bus(bus_s));
    sample_mac_pipe #(.SHIFT(2), .ROUND(1)) dut_r (.clk(clk), .reset(reset), .ce(ce), .bus(bus_r));

    // Record every result actually consumed downstream.
    always @(negedge clk) begin
        if (reset && ce && bus_d.out_valid && out_ready) begin
            got_q.push_back({bus_r.out_ovf, bus_r.dout, bus_s.out_ovf, bus_s.dout,
                             bus_d.out_ovf, bus_d.dout});
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, limit 400000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [13:0] ref_scale(input longint v, input int sh, input bit rnd, input bit sat);
        if (rnd && sh > 0) v = v + (longint'(1) <<< (sh - 1));
        v = v >>> sh;
        if (sat) begin
            if (v > 4095) return {1'b1, 13'h0FFF};
            if (v < -4096) return {1'b1, 13'h1000};
        end
        return {1'b0, v[12:0]};
    endfunction

    function automatic logic [41:0] model_out(input longint v);
        return {ref_scale(v, 2, 1'b1, 1'b0), ref_scale(v, 0, 1'b0, 1'b1), ref_scale(v, 0, 1'b0, 1'b0)};
    endfunction

    function automatic longint wrap_acc(input longint x);
        return (x <<< 34) >>> 34;
    endfunction

    task automatic model_accept(input logic signed [12:0] a, input logic signed [12:0] b,
                                input logic m, input logic f, input logic l);
        longint p;
        p = longint'(a) * longint'(b);
        if (!m) begin
            exp_q.push_back(model_out(p));
        end else begin
            model_acc = wrap_acc((f ? 64'sd0 : model_acc) + p);
            if (l) exp_q.push_back(model_out(model_acc));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic signed [12:0] a, input logic signed [12:0] b,
                        input logic m, input logic f, input logic l);
        int n;
        din0 = a; din1 = b; mode = m; in_first = f; in_last = l; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus_d.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready stayed %0b, want 1", bus_d.in_ready);
            @(posedge clk);
        end else begin
            @(posedge clk);
            model_accept(a, b, m, f, l);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int k;
        k = 0;
        while (got_q.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        repeat (6) @(negedge clk);
        step();
    endtask

    task automatic clear_queues();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (bus_d.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid: got %b want 0", bus_d.out_valid); end
        checks++; if (bus_d.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_in_ready: got %b want 0", bus_d.in_ready); end
        checks++; if (bus_d.dout !== 13'd0) begin errors++; $display("[TB] FAIL rst_dout: got %h want 0", bus_d.dout); end
        checks++; if (bus_s.out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL rst_ovf: got %b want 0", bus_s.out_ovf); end
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_latency();
        int lat;
        clear_queues();
        push(13'sd100, -13'sd3, 1'b0, 1'b0, 1'b0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus_d.out_valid && lat < 20);
        checks++; if (lat != 3) begin errors++; $display("[TB] FAIL lat_mul: got %0d want 3", lat); end
        checks++; if (bus_d.dout !== 13'h1ED4) begin errors++; $display("[TB] FAIL mul_dout: got %h want 1ed4", bus_d.dout); end
        checks++; if (bus_d.out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL mul_ovf: got %b want 0", bus_d.out_ovf); end
        wait_results(1);
        checks++; if (got_q.size() != 1) begin errors++; $display("[TB] FAIL mul_count: got %0d want 1", got_q.size()); end
        else begin checks++; if (got_q[0] !== exp_q[0]) begin errors++; $display("[TB] FAIL mul_model: got %h want %h", got_q[0], exp_q[0]); end end
    endtask

    task automatic test_saturation();
        clear_queues();
        push(13'sd4095, 13'sd4095, 1'b0, 1'b0, 1'b0);
        wait_results(1);
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("[TB] FAIL sat_count: got %0d want 1", got_q.size());
        end else begin
            checks++; if (got_q[0][13:0] !== 14'h0001) begin errors++; $display("[TB] FAIL wrap_dout: got %h want 0001", got_q[0][13:0]); end
            checks++; if (got_q[0][27:14] !== 14'h2FFF) begin errors++; $display("[TB] FAIL sat_dout: got %h want 2fff", got_q[0][27:14]); end
            checks++; if (got_q[0] !== exp_q[0]) begin errors++; $display("[TB] FAIL sat_model: got %h want %h", got_q[0], exp_q[0]); end
        end
    endtask

    task automatic test_accumulate();
        int lat;
        clear_queues();
        push(13'sd1, 13'sd2, 1'b1, 1'b1, 1'b0);
        push(13'sd3, 13'sd4, 1'b1, 1'b0, 1'b0);
        push(13'sd5, 13'sd6, 1'b1, 1'b0, 1'b1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus_d.out_valid && lat < 20);
        checks++; if (lat != 3) begin errors++; $display("[TB] FAIL lat_acc: got %0d want 3", lat); end
        checks++; if (bus_d.dout !== 13'd44) begin errors++; $display("[TB] FAIL acc_dout: got %0d want 44", bus_d.dout); end
        wait_results(1);
        checks++; if (got_q.size() != 1) begin errors++; $display("[TB] FAIL acc_count: got %0d want 1", got_q.size()); end
        clear_queues();
        push(13'sd2, 13'sd2, 1'b1, 1'b1, 1'b0);
        push(13'sd10, 13'sd10, 1'b0, 1'b0, 1'b0);
        push(13'sd1, 13'sd1, 1'b1, 1'b0, 1'b1);
        push(13'sd3, 13'sd3, 1'b1, 1'b0, 1'b1);
        wait_results(3);
        checks++;
        if (got_q.size() != 3) begin
            errors++; $display("[TB] FAIL interleave_count: got %0d want 3", got_q.size());
        end else begin
            checks++; if (got_q[0][12:0] !== 13'd100) begin errors++; $display("[TB] FAIL interleave_mul: got %0d want 100", got_q[0][12:0]); end
            checks++; if (got_q[1][12:0] !== 13'd5) begin errors++; $display("[TB] FAIL interleave_acc: got %0d want 5", got_q[1][12:0]); end
            checks++; if (got_q[2][12:0] !== 13'd14) begin errors++; $display("[TB] FAIL last_no_first: got %0d want 14", got_q[2][12:0]); end
            for (int i = 0; i < 3; i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL interleave_model[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_round();
        clear_queues();
        push(13'sd3, 13'sd3, 1'b0, 1'b0, 1'b0);
        push(-13'sd3, 13'sd3, 1'b0, 1'b0, 1'b0);
        wait_results(2);
        checks++;
        if (got_q.size() != 2) begin
            errors++; $display("[TB] FAIL round_count: got %0d want 2", got_q.size());
        end else begin
            checks++; if (got_q[0][41:28] !== 14'h0002) begin errors++; $display("[TB] FAIL round_pos: got %h want 0002", got_q[0][41:28]); end
            checks++; if (got_q[1][41:28] !== 14'h1FFE) begin errors++; $display("[TB] FAIL round_neg: got %h want 1ffe", got_q[1][41:28]); end
        end
    endtask

    task automatic test_back_to_back();
        clear_queues();
        for (int i = 0; i < 8; i++) begin
            sa[i] = 13'($urandom);
            sb[i] = 13'($urandom);
        end
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) push(sa[i], sb[i], 1'b0, 1'b0, 1'b0);
            end
            begin
                int k;
                logic [12:0] held;
                k = 0;
                @(negedge clk);
                while (!bus_d.out_valid && k < 100) begin @(negedge clk); k++; end
                held = bus_d.dout;
                for (int c = 0; c < 5; c++) begin
                    if (c > 0) @(negedge clk);
                    checks++; if (bus_d.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready: got %b want 0", bus_d.in_ready); end
                    checks++; if (bus_d.dout !== held) begin errors++; $display("[TB] FAIL stall_dout: got %h want %h", bus_d.dout, held); end
                end
                step();
                out_ready = 1'b1;
            end
        join
        wait_results(8);
        checks++;
        if (got_q.size() != 8) begin
            errors++; $display("[TB] FAIL stall_count: got %0d want 8", got_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL stall_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
            end
        end
        first_run = got_q;
    endtask

    task automatic test_ce_freeze();
        clear_queues();
        fork
            begin
                for (int i = 0; i < 8; i++) push(sa[i], sb[i], 1'b0, 1'b0, 1'b0);
            end
            begin
                logic [12:0] held;
                repeat (3) step();
                ce = 1'b0;
                held = bus_d.dout;
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    checks++; if (bus_d.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL ce_in_ready: got %b want 0", bus_d.in_ready); end
                    checks++; if (bus_d.dout !== held) begin errors++; $display("[TB] FAIL ce_dout: got %h want %h", bus_d.dout, held); end
                end
                step();
                ce = 1'b1;
            end
        join
        wait_results(8);
        checks++;
        if (got_q.size() != 8 || first_run.size() != 8) begin
            errors++; $display("[TB] FAIL ce_count: got %0d want 8", got_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++; if (got_q[i] !== first_run[i] || got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL ce_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int k;
        clear_queues();
        out_ready = 1'b0;
        push(13'sd7, 13'sd7, 1'b1, 1'b1, 1'b0);
        push(13'sd5, 13'sd5, 1'b0, 1'b0, 1'b0);
        k = 0;
        @(negedge clk);
        while (!bus_d.out_valid && k < 50) begin @(negedge clk); k++; end
        checks++; if (bus_d.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_valid: got %b want 1", bus_d.out_valid); end
        #2 reset = 1'b0;
        model_acc = 0;
        #1;
        checks++; if (bus_d.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_out_valid: got %b want 0", bus_d.out_valid); end
        checks++; if (bus_d.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL async_in_ready: got %b want 0", bus_d.in_ready); end
        @(posedge clk);
        #3 reset = 1'b1;
        out_ready = 1'b1;
        step();
        clear_queues();
        push(13'sd1, 13'sd1, 1'b1, 1'b0, 1'b1);
        push(13'sd2, 13'sd3, 1'b1, 1'b1, 1'b1);
        wait_results(2);
        checks++;
        if (got_q.size() != 2) begin
            errors++; $display("[TB] FAIL post_reset_count: got %0d want 2", got_q.size());
        end else begin
            checks++; if (got_q[0][12:0] !== 13'd1) begin errors++; $display("[TB] FAIL acc_cleared: got %0d want 1", got_q[0][12:0]); end
            checks++; if (got_q[1][12:0] !== 13'd6) begin errors++; $display("[TB] FAIL post_reset_dout: got %0d want 6", got_q[1][12:0]); end
        end
    endtask

    task automatic test_random();
        clear_queues();
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    push(13'($urandom), 13'($urandom), 1'($urandom_range(0, 1)),
                         ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
                end
            end
            begin
                repeat (60) begin
                    step();
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        wait_results(exp_q.size());
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("[TB] FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL rand_result[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        $display("[TB] sample_mac_pipe bench start");
        test_reset();
        test_latency();
        test_saturation();
        test_accumulate();
        test_round();
        test_back_to_back();
        test_ce_freeze();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
